// File: rtl/rect_draw.sv
// Column-major rectangle rasteriser: one pixel per clock for w*h cycles, then a one-cycle done pulse.
// No backpressure: start is honoured only in IDLE; requests while busy are dropped, not queued.
module rect_draw #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int SIZE_W   = 7,
   parameter int COLOR_W  = 3,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic [X_W-1:0]     x_in,
   input  logic [Y_W-1:0]     y_in,
   input  logic [SIZE_W-1:0]  w_in,
   input  logic [SIZE_W-1:0]  h_in,
   input  logic [COLOR_W-1:0] color_in,
   input  logic [COLOR_W-1:0] bg_color,
   input  logic               erase,
   output logic               busy,
   output logic               done,
   output logic               writeEn,
   output logic [X_W-1:0]     x_out,
   output logic [Y_W-1:0]     y_out,
   output logic [COLOR_W-1:0] color_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [X_W:0]    SCR_W = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0]    SCR_H = (Y_W+1)'(SCREEN_H);
   localparam logic [SIZE_W-1:0] ONE = SIZE_W'(1);

   state_t state, state_nxt;

   logic [X_W-1:0]     x0;
   logic [Y_W-1:0]     y0;
   logic [SIZE_W-1:0]  w;
   logic [SIZE_W-1:0]  h;
   logic [COLOR_W-1:0] col;
   logic [SIZE_W-1:0]  cx;
   logic [SIZE_W-1:0]  cy;

   logic               req_ok;
   logic               col_end;
   logic               last_pix;
   logic [X_W:0]       sum_x;
   logic [Y_W:0]       sum_y;

   // A request that would produce no visible origin is completed immediately.
   assign req_ok   = (w_in != '0) && (h_in != '0) &&
                     ({1'b0, x_in} < SCR_W) && ({1'b0, y_in} < SCR_H);
   assign col_end  = (cy == h - ONE);
   assign last_pix = col_end && (cx == w - ONE);

   // Sums carry one extra bit so that wrap-around can never sneak a pixel on-screen.
   assign sum_x = {1'b0, x0} + (X_W+1)'(cx);
   assign sum_y = {1'b0, y0} + (Y_W+1)'(cy);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = req_ok ? DRAW : DONE;
            end
         end
         DRAW: begin
            if (last_pix) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      done      = (state == DONE);
      writeEn   = (state == DRAW) && (sum_x < SCR_W) && (sum_y < SCR_H);
      x_out     = sum_x[X_W-1:0];
      y_out     = sum_y[Y_W-1:0];
      color_out = col;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         x0  <= '0;
         y0  <= '0;
         w   <= '0;
         h   <= '0;
         col <= '0;
         cx  <= '0;
         cy  <= '0;
      end else if (state == IDLE) begin
         if (start && req_ok) begin
            x0  <= x_in;
            y0  <= y_in;
            w   <= w_in;
            h   <= h_in;
            col <= erase ? bg_color : color_in;
            cx  <= '0;
            cy  <= '0;
         end
      end else if (state == DRAW) begin
         if (col_end) begin
            cy <= '0;
            cx <= cx + ONE;
         end else begin
            cy <= cy + ONE;
         end
      end
   end

endmodule

// File: tb/tb_rect_draw.sv
// Directed bench for rect_draw: per-cycle pixel sequence, clipping, degenerate requests, start-ignore and reset abort.
module tb_rect_draw;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start;
   logic [7:0] x_in;
   logic [6:0] y_in;
   logic [6:0] w_in;
   logic [6:0] h_in;
   logic [2:0] color_in;
   logic [2:0] bg_color;
   logic       erase;
   logic       busy;
   logic       done;
   logic       write_en;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] color_out;

   int n_checks = 0;
   int n_errors = 0;

   logic [17:0] px_q[$];
   int t1x[6] = '{10, 10, 10, 11, 11, 11};
   int t1y[6] = '{20, 21, 22, 20, 21, 22};

   rect_draw dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .x_in      (x_in),
      .y_in      (y_in),
      .w_in      (w_in),
      .h_in      (h_in),
      .color_in  (color_in),
      .bg_color  (bg_color),
      .erase     (erase),
      .busy      (busy),
      .done      (done),
      .writeEn   (write_en),
      .x_out     (x_out),
      .y_out     (y_out),
      .color_out (color_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Issue one request and watch every cycle until two cycles after done is due.
   // n_pix = w*h for an accepted request, 0 for a degenerate one.
   task automatic run_rect(input string tag, input int x, input int y, input int w, input int h,
                           input int col, input int er, input int bg,
                           input int n_pix, input int exp_writes, input int poke);
      int mism;
      int writes;
      int dones;
      int ex;
      int ey;
      int expc;
      logic expw;
      mism   = 0;
      writes = 0;
      dones  = 0;
      expc   = (er != 0) ? bg : col;
      px_q.delete();
      @(negedge clk);
      x_in     = 8'(x);
      y_in     = 7'(y);
      w_in     = 7'(w);
      h_in     = 7'(h);
      color_in = 3'(col);
      bg_color = 3'(bg);
      erase    = (er != 0);
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      x_in     = 8'd3;
      y_in     = 7'd5;
      w_in     = 7'd9;
      h_in     = 7'd9;
      color_in = 3'd7;
      bg_color = 3'd6;
      erase    = 1'b0;
      for (int c = 1; c <= n_pix + 2; c++) begin
         @(negedge clk);
         if (c <= n_pix) begin
            ex   = x + (c - 1) / h;
            ey   = y + (c - 1) % h;
            expw = (ex < 160) && (ey < 120);
            if (write_en !== expw || busy !== 1'b1 || done !== 1'b0) mism++;
            if (expw && (x_out !== 8'(ex) || y_out !== 7'(ey) || color_out !== 3'(expc))) mism++;
         end else if (c == n_pix + 1) begin
            if (busy !== 1'b1 || done !== 1'b1 || write_en !== 1'b0) mism++;
         end else begin
            if (busy !== 1'b0 || done !== 1'b0 || write_en !== 1'b0) mism++;
         end
         if (write_en === 1'b1) begin
            writes++;
            px_q.push_back({x_out, y_out, color_out});
         end
         if (done === 1'b1) dones++;
         if (poke != 0 && c == poke) begin
            start = 1'b1;
            x_in  = 8'd0;
            y_in  = 7'd0;
            w_in  = 7'd5;
            h_in  = 7'd5;
         end
         if (poke != 0 && c == poke + 1) start = 1'b0;
      end
      chk({tag, " cycle_mismatches"}, mism, 0);
      chk({tag, " writes"}, writes, exp_writes);
      chk({tag, " done_pulses"}, dones, 1);
   endtask

   task automatic chk_t1_pixels(input string tag, input int exp_col);
      chk({tag, " px_count"}, px_q.size(), 6);
      for (int i = 0; i < px_q.size() && i < 6; i++) begin
         chk($sformatf("%s px%0d x", tag, i), px_q[i][17:10], t1x[i]);
         chk($sformatf("%s px%0d y", tag, i), px_q[i][9:3], t1y[i]);
         chk($sformatf("%s px%0d col", tag, i), px_q[i][2:0], exp_col);
      end
   endtask

   initial begin
      int dones;
      resetn   = 1'b0;
      start    = 1'b0;
      x_in     = '0;
      y_in     = '0;
      w_in     = '0;
      h_in     = '0;
      color_in = '0;
      bg_color = '0;
      erase    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst writeEn", write_en, 0);
      chk("rst x_out", x_out, 0);
      chk("rst y_out", y_out, 0);
      chk("rst color_out", color_out, 0);
      resetn = 1'b1;

      run_rect("t1", 10, 20, 2, 3, 4, 0, 0, 6, 6, 0);
      chk_t1_pixels("t1", 4);

      run_rect("t2", 10, 20, 2, 3, 4, 1, 0, 6, 6, 0);
      chk_t1_pixels("t2", 0);

      run_rect("t3", 158, 118, 4, 4, 5, 0, 0, 16, 4, 0);
      chk("t3 first px", px_q.size() > 0 ? px_q[0] : 18'h0, {8'd158, 7'd118, 3'd5});
      chk("t3 last px", px_q.size() > 0 ? px_q[px_q.size()-1] : 18'h0, {8'd159, 7'd119, 3'd5});

      run_rect("t4w", 10, 10, 0, 5, 2, 0, 0, 0, 0, 0);
      run_rect("t4x", 160, 10, 4, 4, 2, 0, 0, 0, 0, 0);
      run_rect("t4y", 10, 120, 4, 4, 2, 0, 0, 0, 0, 0);

      run_rect("t5 poke", 10, 20, 2, 3, 4, 0, 0, 6, 6, 3);
      chk_t1_pixels("t5 poke", 4);

      // Abort after the third pixel.
      @(negedge clk);
      x_in     = 8'd10;
      y_in     = 7'd20;
      w_in     = 7'd2;
      h_in     = 7'd3;
      color_in = 3'd4;
      erase    = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5 rst pre writeEn", write_en, 1);
      chk("t5 rst pre y_out", y_out, 22);
      resetn = 1'b0;
      @(negedge clk);
      chk("t5 rst writeEn", write_en, 0);
      chk("t5 rst busy", busy, 0);
      chk("t5 rst done", done, 0);
      resetn = 1'b1;
      dones = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      chk("t5 rst no_done", dones, 0);
      run_rect("t5 fresh", 10, 20, 2, 3, 4, 0, 0, 6, 6, 0);
      chk_t1_pixels("t5 fresh", 4);

      run_rect("t6", 0, 0, 127, 127, 1, 0, 0, 16129, 15240, 0);
      chk("t6 last written px", px_q.size() > 0 ? px_q[px_q.size()-1] : 18'h0, {8'd126, 7'd119, 3'd1});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
